// File: rtl/move_list_walker_pkg.sv
// move_list_walker_pkg: shared walker state encoding and move-RAM latency bounds.
// Optional feature macro used across the slice: MOVE_WALK_BEST_EN.
package move_list_walker_pkg;
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_READY = 3'd1,
        WAIT_RAM   = 3'd2,
        EVAL       = 3'd3,
        PRESENT    = 3'd4,
        CLEAR      = 3'd5,
        CLEAR_WAIT = 3'd6,
        FINISH     = 3'd7
    } walk_state_t;
    localparam int RAM_LATENCY_MIN = 1;
    localparam int RAM_LATENCY_MAX = 8;
    function automatic int clamp_latency(input int l);
        return l < RAM_LATENCY_MIN ? RAM_LATENCY_MIN : l > RAM_LATENCY_MAX ? RAM_LATENCY_MAX : l;
    endfunction
endpackage

// File: rtl/move_list_walker_if.sv
// move_list_walker_if: move-RAM, control and output-stream signals of the walker.
// MOVE_WALK_BEST_EN adds the white-to-move input and best-move result signals.
interface move_list_walker_if #(
    parameter int MAX_POSITIONS_LOG2 = 8,
    parameter int EVAL_WIDTH = 22,
    parameter int UCI_WIDTH = 16
);
    logic start_in;
    logic capture_filter_in;
    logic am_moves_ready;
    logic [MAX_POSITIONS_LOG2-1:0] am_move_count;
    logic initial_mate;
    logic initial_stalemate;
    logic [UCI_WIDTH-1:0] uci_in;
    logic signed [EVAL_WIDTH-1:0] eval_in;
    logic capture_in;
    logic [MAX_POSITIONS_LOG2-1:0] am_move_index;
    logic am_clear_moves;
    logic out_valid;
    logic out_ready;
    logic [UCI_WIDTH-1:0] out_uci;
    logic signed [EVAL_WIDTH-1:0] out_eval;
    logic [MAX_POSITIONS_LOG2-1:0] out_index;
    logic out_last;
    logic done;
    logic [1:0] terminal;
    logic busy;
`ifdef MOVE_WALK_BEST_EN
    logic white_to_move_in;
    logic best_valid;
    logic [MAX_POSITIONS_LOG2-1:0] best_index;
    logic signed [EVAL_WIDTH-1:0] best_eval;
`endif
    modport master (
        input  start_in, capture_filter_in, am_moves_ready, am_move_count, initial_mate,
               initial_stalemate, uci_in, eval_in, capture_in, out_ready,
`ifdef MOVE_WALK_BEST_EN
        input  white_to_move_in,
        output best_valid, best_index, best_eval,
`endif
        output am_move_index, am_clear_moves, out_valid, out_uci, out_eval, out_index,
               out_last, done, terminal, busy
    );
    modport slave (
        output start_in, capture_filter_in, am_moves_ready, am_move_count, initial_mate,
               initial_stalemate, uci_in, eval_in, capture_in, out_ready,
`ifdef MOVE_WALK_BEST_EN
        output white_to_move_in,
        input  best_valid, best_index, best_eval,
`endif
        input  am_move_index, am_clear_moves, out_valid, out_uci, out_eval, out_index,
               out_last, done, terminal, busy
    );
endinterface

// File: rtl/move_list_walker_best_tracker.sv
// move_best_tracker: best eval over emitted moves (max for white, min for black).
// Only instantiated when MOVE_WALK_BEST_EN is defined.
module move_best_tracker #(
    parameter int MAX_POSITIONS_LOG2 = 8,
    parameter int EVAL_WIDTH = 22
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic update,
    input  logic white_in,
    input  logic signed [EVAL_WIDTH-1:0] eval,
    input  logic [MAX_POSITIONS_LOG2-1:0] index,
    output logic best_valid,
    output logic [MAX_POSITIONS_LOG2-1:0] best_index,
    output logic signed [EVAL_WIDTH-1:0] best_eval
);
    logic white;
    logic take;
    // strict compare keeps the earlier (lower) index on ties
    assign take = update && (!best_valid || (white ? eval > best_eval : eval < best_eval));
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            best_valid <= 1'b0;
            best_index <= '0;
            best_eval <= '0;
            white <= reset ? 1'b0 : white_in;
        end else if (take) begin
            best_valid <= 1'b1;
            best_index <= index;
            best_eval <= eval;
        end
    end
endmodule

// File: rtl/move_list_walker.sv
// move_list_walker: walks the generated move list, emitting (optionally capture-only) moves.
// MOVE_WALK_BEST_EN adds best-move tracking through move_best_tracker.
module move_list_walker
    import move_list_walker_pkg::*;
#(
    parameter int MAX_POSITIONS_LOG2 = 8,
    parameter int EVAL_WIDTH = 22,
    parameter int UCI_WIDTH = 16,
    parameter int RAM_LATENCY = 2
) (
    input logic clk,
    input logic reset,
    move_list_walker_if.master bus
);
    localparam int LAT = clamp_latency(RAM_LATENCY);
    localparam logic [2:0] LAT_END = 3'(LAT - 1);
    walk_state_t state, state_n;
    logic filt;
    logic [2:0] wait_cnt;
    logic [MAX_POSITIONS_LOG2-1:0] idx;
    logic [1:0] term;
    logic [UCI_WIDTH-1:0] uci_r;
    logic signed [EVAL_WIDTH-1:0] eval_r;
    logic [MAX_POSITIONS_LOG2-1:0] index_r;
    logic last_r;
    logic is_last;
    logic skip;
    logic adv;
    logic start;
    // widened compare so a full-range count never wraps back to index 0
    assign is_last = ({1'b0, idx} + {{MAX_POSITIONS_LOG2{1'b0}}, 1'b1}) == {1'b0, bus.am_move_count};
    assign skip = filt && !bus.capture_in;
    assign start = state == IDLE && bus.start_in;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:       state_n = bus.start_in ? WAIT_READY : IDLE;
            WAIT_READY: state_n = !bus.am_moves_ready ? WAIT_READY : bus.am_move_count == '0 ? CLEAR : WAIT_RAM;
            WAIT_RAM:   state_n = wait_cnt == LAT_END ? EVAL : WAIT_RAM;
            EVAL:       state_n = !skip ? PRESENT : is_last ? CLEAR : WAIT_RAM;
            PRESENT:    state_n = !bus.out_ready ? PRESENT : is_last ? CLEAR : WAIT_RAM;
            CLEAR:      state_n = CLEAR_WAIT;
            CLEAR_WAIT: state_n = FINISH;
            default:    state_n = IDLE;
        endcase
    end
    assign adv = state_n == WAIT_RAM && (state == EVAL || state == PRESENT);
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            filt <= 1'b0;
            wait_cnt <= '0;
            idx <= '0;
            term <= '0;
            uci_r <= '0;
            eval_r <= '0;
            index_r <= '0;
            last_r <= 1'b0;
        end else begin
            state <= state_n;
            wait_cnt <= state == WAIT_RAM ? wait_cnt + 3'd1 : 3'd0;
            if (start) begin
                filt <= bus.capture_filter_in;
                idx <= '0;
                term <= '0;
            end
            if (state == WAIT_READY && bus.am_moves_ready && bus.am_move_count == '0)
                term <= {bus.initial_mate, bus.initial_stalemate};
            if (adv)
                idx <= idx + 1'b1;
            if (state == EVAL) begin
                uci_r <= bus.uci_in;
                eval_r <= bus.eval_in;
                index_r <= idx;
                last_r <= is_last;
            end
        end
    end
    assign bus.am_move_index = idx;
    assign bus.am_clear_moves = state == CLEAR;
    assign bus.out_valid = state == PRESENT;
    assign bus.out_uci = uci_r;
    assign bus.out_eval = eval_r;
    assign bus.out_index = index_r;
    assign bus.out_last = state == PRESENT && last_r;
    assign bus.done = state == FINISH;
    assign bus.terminal = state == FINISH ? term : 2'b00;
    assign bus.busy = state != IDLE;
`ifdef MOVE_WALK_BEST_EN
    move_best_tracker #(
        .MAX_POSITIONS_LOG2(MAX_POSITIONS_LOG2),
        .EVAL_WIDTH(EVAL_WIDTH)
    ) u_best (
        .clk(clk),
        .reset(reset),
        .clear(start),
        .update(state == PRESENT && bus.out_ready),
        .white_in(bus.white_to_move_in),
        .eval(eval_r),
        .index(index_r),
        .best_valid(bus.best_valid),
        .best_index(bus.best_index),
        .best_eval(bus.best_eval)
    );
`endif
endmodule

// File: tb/tb_move_list_walker.sv
// tb_move_list_walker: directed walks against a queue-based model of the emitted stream.
// Best-move checks are compiled only with MOVE_WALK_BEST_EN.
module tb_move_list_walker;
    localparam int W = 8;
    localparam int E = 22;
    localparam int U = 16;
    localparam int L = 2;
    typedef struct {
        int idx;
        logic [U-1:0] uci;
        logic signed [E-1:0] ev;
        logic last;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    move_list_walker_if #(.MAX_POSITIONS_LOG2(W), .EVAL_WIDTH(E), .UCI_WIDTH(U)) bus ();
    move_list_walker #(
        .MAX_POSITIONS_LOG2(W),
        .EVAL_WIDTH(E),
        .UCI_WIDTH(U),
        .RAM_LATENCY(L)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    logic [U-1:0] mem_uci [256];
    logic signed [E-1:0] mem_eval [256];
    logic mem_cap [256];
    logic [W-1:0] pipe [L];
    // move RAM: data reflects the address presented L edges earlier
    always @(posedge clk) begin
        pipe[0] <= bus.am_move_index;
        for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
    assign bus.uci_in = mem_uci[pipe[L-1]];
    assign bus.eval_in = mem_eval[pipe[L-1]];
    assign bus.capture_in = mem_cap[pipe[L-1]];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int stall = 0;
    int clr_cnt, clr_cyc, done_cyc, last_seen;
    bit done_seen;
    logic [1:0] exp_term;
    exp_t exp_q[$];
    int emitted[$];
    int xfer_cyc[$];
    bit cur_white;
    bit mb_valid;
    int mb_idx;
    longint mb_eval;
    longint rec_best_idx, rec_best_eval;
    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask
    task automatic observe();
        if (bus.am_clear_moves) begin
            clr_cnt++;
            clr_cyc = cyc;
        end
        if (bus.out_valid) begin
            if (exp_q.size() == 0) chk("extra_valid", 1, 0);
            else begin
                chk("out_index", longint'(bus.out_index), exp_q[0].idx);
                chk("out_uci", longint'(bus.out_uci), longint'(exp_q[0].uci));
                chk("out_eval", longint'(bus.out_eval), longint'(exp_q[0].ev));
                chk("out_last", longint'(bus.out_last), longint'(exp_q[0].last));
                if (bus.out_last) last_seen = int'(bus.out_index);
                if (bus.out_ready) begin
                    emitted.push_back(exp_q[0].idx);
                    xfer_cyc.push_back(cyc);
                    if (!mb_valid || (cur_white ? longint'(exp_q[0].ev) > mb_eval : longint'(exp_q[0].ev) < mb_eval)) begin
                        mb_valid = 1'b1;
                        mb_idx = exp_q[0].idx;
                        mb_eval = longint'(exp_q[0].ev);
                    end
                    exp_q.delete(0);
                end
            end
        end
        if (bus.done) begin
            done_seen = 1'b1;
            done_cyc = cyc;
            chk("terminal", longint'(bus.terminal), longint'(exp_term));
            chk("moves_left_at_done", exp_q.size(), 0);
`ifdef MOVE_WALK_BEST_EN
            chk("best_valid", longint'(bus.best_valid), longint'(mb_valid));
            rec_best_idx = longint'(bus.best_index);
            rec_best_eval = longint'(bus.best_eval);
            if (mb_valid) begin
                chk("best_index", rec_best_idx, mb_idx);
                chk("best_eval", rec_best_eval, mb_eval);
            end
`endif
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (stall > 0 && bus.out_valid) begin
            bus.out_ready = 1'b0;
            stall--;
        end else bus.out_ready = 1'b1;
        observe();
    endtask
    task automatic set_move(input int i, input int uci, input int ev, input bit cap);
        mem_uci[i] = U'(uci);
        mem_eval[i] = E'(ev);
        mem_cap[i] = cap;
    endtask
    task automatic begin_walk(input int count, input bit filt, input bit mate, input bit stale, input int stall_n, input bit white);
        exp_q.delete();
        emitted.delete();
        xfer_cyc.delete();
        clr_cnt = 0;
        done_seen = 1'b0;
        last_seen = -1;
        stall = stall_n;
        cur_white = white;
        mb_valid = 1'b0;
        exp_term = count == 0 ? {mate, stale} : 2'b00;
        for (int i = 0; i < count; i++)
            if (!filt || mem_cap[i]) exp_q.push_back('{i, mem_uci[i], mem_eval[i], i == count - 1});
        bus.am_move_count = W'(count);
        bus.initial_mate = mate;
        bus.initial_stalemate = stale;
        bus.capture_filter_in = filt;
`ifdef MOVE_WALK_BEST_EN
        bus.white_to_move_in = white;
`endif
        bus.start_in = 1'b1;
        step();
        bus.start_in = 1'b0;
        bus.capture_filter_in = 1'b0;
        chk("busy_after_start", longint'(bus.busy), 1);
        step();
        step();
        bus.am_moves_ready = 1'b1;
        step();
    endtask
    task automatic walk(input int count, input bit filt, input bit mate, input bit stale, input int stall_n, input bit white);
        begin_walk(count, filt, mate, stale, stall_n, white);
        bus.am_moves_ready = 1'b0;
        bus.start_in = 1'b1;
        step();
        bus.start_in = 1'b0;
        for (int n = 0; n < 500 && !done_seen; n++) step();
        if (!done_seen) chk("done_timeout", 0, 1);
        chk("clear_pulses", clr_cnt, 1);
        chk("done_after_clear", done_cyc - clr_cyc, 2);
        step();
        chk("busy_after_done", longint'(bus.busy), 0);
    endtask
    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_index"}, longint'(bus.am_move_index), 0);
        chk({tag, "_clear"}, longint'(bus.am_clear_moves), 0);
        chk({tag, "_valid"}, longint'(bus.out_valid), 0);
        chk({tag, "_done"}, longint'(bus.done), 0);
        chk({tag, "_busy"}, longint'(bus.busy), 0);
        chk({tag, "_terminal"}, longint'(bus.terminal), 0);
        chk({tag, "_uci"}, longint'(bus.out_uci), 0);
        chk({tag, "_eval"}, longint'(bus.out_eval), 0);
        chk({tag, "_out_index"}, longint'(bus.out_index), 0);
        chk({tag, "_last"}, longint'(bus.out_last), 0);
    endtask
    initial begin
        bus.start_in = 1'b0;
        bus.capture_filter_in = 1'b0;
        bus.am_moves_ready = 1'b0;
        bus.am_move_count = '0;
        bus.initial_mate = 1'b0;
        bus.initial_stalemate = 1'b0;
        bus.out_ready = 1'b1;
`ifdef MOVE_WALK_BEST_EN
        bus.white_to_move_in = 1'b0;
`endif
        for (int i = 0; i < 256; i++) set_move(i, 16'h0a00 + i, 0, 1'b0);
        step();
        step();
        reset = 1'b0;
        chk_idle_outputs("reset");
        set_move(0, 16'h1234, 100, 1'b0);
        set_move(1, 16'h2345, -50, 1'b1);
        set_move(2, 16'h3456, 7, 1'b0);
        set_move(3, 16'h4567, -900, 1'b1);
        walk(3, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        chk("w1_count", emitted.size(), 3);
        if (emitted.size() == 3) begin
            chk("w1_first", emitted[0], 0);
            chk("w1_third", emitted[2], 2);
            chk("w1_spacing", xfer_cyc[1] - xfer_cyc[0], L + 2);
        end
        chk("w1_last_index", last_seen, 2);
        walk(0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        chk("w2_count", emitted.size(), 0);
        walk(4, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        chk("w3_count", emitted.size(), 2);
        if (emitted.size() == 2) begin
            chk("w3_first", emitted[0], 1);
            chk("w3_second", emitted[1], 3);
        end
        chk("w3_last_index", last_seen, 3);
        walk(2, 1'b0, 1'b0, 1'b0, 5, 1'b1);
        chk("w4_count", emitted.size(), 2);
        set_move(2, 16'h3456, 7, 1'b1);
        set_move(3, 16'h4567, -900, 1'b0);
        walk(4, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        chk("w5_count", emitted.size(), 2);
        chk("w5_no_last", last_seen, -1);
        walk(0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        begin_walk(4, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        bus.am_moves_ready = 1'b0;
        for (int n = 0; n < 200 && bus.am_move_index != W'(2); n++) step();
        chk("rst_reached_index2", longint'(bus.am_move_index), 2);
        reset = 1'b1;
        step();
        chk_idle_outputs("midreset");
        reset = 1'b0;
        exp_q.delete();
        clr_cnt = 0;
        for (int n = 0; n < 6; n++) step();
        chk("midreset_no_clear", clr_cnt, 0);
        chk("midreset_idle", longint'(bus.busy), 0);
`ifdef MOVE_WALK_BEST_EN
        set_move(0, 16'h0101, 5, 1'b0);
        set_move(1, 16'h0202, -3, 1'b0);
        set_move(2, 16'h0303, -3, 1'b0);
        walk(3, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        chk("best_black_index", rec_best_idx, 1);
        chk("best_black_eval", rec_best_eval, -3);
        walk(3, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        chk("best_white_index", rec_best_idx, 0);
        chk("best_white_eval", rec_best_eval, 5);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
